i2c_slave_rx: RTL and testbench

- I2C target-side receiver: the far end of the team's 32-bit I2C write master.
- Watches SCL/SDA, detects START/STOP, and matches the 7-bit address against SLAVE_ADDR.
- Acknowledges by driving SDA low through an open-drain enable, and collects DATA_BYTES bytes into a parallel word.
- Sits on the peripheral side of the bus; the top level provides the SDA tri-state and pull-up.

---
 rtl/i2c_slave_rx.sv | 141 ++++++++++++++
 tb/tb_i2c_slave_rx.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/i2c_slave_rx.sv
// I2C write-only target: synchronizes SCL/SDA, decodes START/STOP, ACKs its address
// and DATA_BYTES data bytes, then presents the assembled word with a one-cycle valid.
`timescale 1ns/1ps
module i2c_slave_rx #(
   parameter logic [6:0] SLAVE_ADDR = 7'b1010101,
   parameter int         DATA_BYTES = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i2c_scl,
   input  logic                    i2c_sda,
   output logic                    sda_oe,
   output logic [8*DATA_BYTES-1:0] data_out,
   output logic                    data_valid,
   output logic                    addr_match,
   output logic                    busy,
   output logic                    error
);

   localparam int BW = 8*DATA_BYTES;
   localparam int CW = $clog2(DATA_BYTES+1);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, WAIT_STOP, IGNORE
   } state_t;

   state_t        state;
   logic [2:0]    scl_sync;
   logic [2:0]    sda_sync;
   logic [BW-1:0] shreg;
   logic [3:0]    bit_cnt;
   logic [CW-1:0] byte_cnt;

   logic scl_rise, scl_fall, start_det, stop_det, in_frame, addr_ok;

   // [0],[1] form the synchronizer, [2] is the history flop; idle bus level is high
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_sync <= 3'b111;
         sda_sync <= 3'b111;
      end else begin
         scl_sync <= {scl_sync[1:0], i2c_scl};
         sda_sync <= {sda_sync[1:0], i2c_sda};
      end
   end

   assign scl_rise  =  scl_sync[1] & ~scl_sync[2];
   assign scl_fall  = ~scl_sync[1] &  scl_sync[2];
   assign start_det =  scl_sync[1] &  scl_sync[2] &  sda_sync[2] & ~sda_sync[1];
   assign stop_det  =  scl_sync[1] &  scl_sync[2] & ~sda_sync[2] &  sda_sync[1];
   assign in_frame  = (state == ADDR) || (state == ADDR_ACK) ||
                      (state == DATA) || (state == DATA_ACK);
   assign addr_ok   = (shreg[7:1] == SLAVE_ADDR) && !shreg[0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         sda_oe     <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         addr_match <= 1'b0;
         busy       <= 1'b0;
         error      <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= '0;
         byte_cnt   <= '0;
      end else begin
         data_valid <= 1'b0;
         error      <= 1'b0;
         if (stop_det) begin
            state      <= IDLE;
            busy       <= 1'b0;
            addr_match <= 1'b0;
            sda_oe     <= 1'b0;
            error      <= in_frame;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
         end else if (start_det) begin
            state      <= ADDR;
            busy       <= 1'b1;
            addr_match <= 1'b0;
            sda_oe     <= 1'b0;
            error      <= in_frame;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
         end else begin
            case (state)
               ADDR: begin
                  if (scl_rise) begin
                     shreg   <= {shreg[BW-2:0], sda_sync[1]};
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     bit_cnt <= '0;
                     if (addr_ok) begin
                        state      <= ADDR_ACK;
                        sda_oe     <= 1'b1;
                        addr_match <= 1'b1;
                     end else begin
                        state  <= IGNORE;
                        sda_oe <= 1'b0;
                     end
                  end
               end
               ADDR_ACK: begin
                  if (scl_fall) begin
                     sda_oe  <= 1'b0;
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  if (scl_rise) begin
                     shreg   <= {shreg[BW-2:0], sda_sync[1]};
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     state   <= DATA_ACK;
                     sda_oe  <= 1'b1;
                     bit_cnt <= '0;
                  end
               end
               DATA_ACK: begin
                  if (scl_fall) begin
                     sda_oe   <= 1'b0;
                     byte_cnt <= byte_cnt + 1'b1;
                     // the last byte's ACK has finished: publish the whole word
                     if (byte_cnt == CW'(DATA_BYTES-1)) begin
                        data_out   <= shreg;
                        data_valid <= 1'b1;
                        state      <= WAIT_STOP;
                     end else begin
                        state <= DATA;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-banged I2C master, expected words queued per frame sent.
`timescale 1ns/1ps
module tb_i2c_slave_rx;

   localparam int Q = 100;
   localparam logic [6:0] SADDR = 7'b1010101;

   logic        clk = 1'b0;
   logic        reset;
   logic        scl_m, sda_m;
   logic        sda_bus;
   logic        sda_oe, data_valid, addr_match, busy, error;
   logic [31:0] data_out;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          err_seen = 0;
   int          exp_err  = 0;
   int          stray    = 0;
   logic        ack_slot = 1'b0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;
   assign sda_bus = sda_m & ~sda_oe;

   i2c_slave_rx #(.SLAVE_ADDR(SADDR), .DATA_BYTES(4)) dut (
      .clk(clk), .reset(reset), .i2c_scl(scl_m), .i2c_sda(sda_bus),
      .sda_oe(sda_oe), .data_out(data_out), .data_valid(data_valid),
      .addr_match(addr_match), .busy(busy), .error(error)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (data_valid) begin
         chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) chk("data_out", data_out, exp_q.pop_front());
      end
      if (error) err_seen++;
      if (sda_oe && scl_m && !ack_slot) stray++;
   end

   task automatic wbit(input logic b);
      sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
   endtask

   task automatic ack(input logic exp, input string tag);
      ack_slot = 1'b1;
      sda_m = 1'b1; #Q; scl_m = 1'b1; #Q;
      chk(tag, 32'(sda_oe), 32'(exp));
      #Q; scl_m = 1'b0; #Q;
      ack_slot = 1'b0;
   endtask

   task automatic wbyte(input logic [7:0] b, input logic exp_ack, input string tag);
      for (int i = 7; i >= 0; i--) wbit(b[i]);
      ack(exp_ack, tag);
   endtask

   task automatic start_c;
      sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
   endtask

   task automatic stop_c;
      sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
   endtask

   task automatic frame(input logic [6:0] a, input logic rw, input logic [31:0] d,
                        input logic match, input int nbytes, input logic do_stop);
      if (match && nbytes == 4) exp_q.push_back(d);
      start_c;
      chk("busy_start", 32'(busy), 32'd1);
      wbyte({a, rw}, match, "ack_addr");
      chk("addr_match", 32'(addr_match), 32'(match));
      for (int k = 0; k < nbytes; k++) wbyte(d[31-8*k -: 8], match, "ack_data");
      if (do_stop) begin
         stop_c;
         chk("busy_stop", 32'(busy), 32'd0);
         chk("addr_match_stop", 32'(addr_match), 32'd0);
         chk("err_cnt", err_seen, exp_err);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_sda_oe"}, 32'(sda_oe), 32'd0);
      chk({tag, "_data_out"}, data_out, 32'd0);
      chk({tag, "_valid"}, 32'(data_valid), 32'd0);
      chk({tag, "_addr_match"}, 32'(addr_match), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_error"}, 32'(error), 32'd0);
   endtask

   initial begin
      reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
      repeat (5) @(negedge clk);
      chk_reset_vals("rst");
      reset = 1'b0;
      #Q;

      // matched write
      frame(SADDR, 1'b0, 32'hAFAFAFAF, 1'b1, 4, 1'b1);
      chk("data_hold_1", data_out, 32'hAFAFAFAF);

      // address mismatch: nothing acked or stored
      frame(7'b1111000, 1'b0, 32'hAA0FF055, 1'b0, 4, 1'b1);
      chk("data_hold_mismatch", data_out, 32'hAFAFAFAF);

      // read request is ignored without error
      frame(SADDR, 1'b1, 32'h0, 1'b0, 0, 1'b1);

      // STOP after two of four bytes aborts the frame
      exp_err++;
      frame(SADDR, 1'b0, 32'h57330000, 1'b1, 2, 1'b1);
      chk("data_hold_abort", data_out, 32'hAFAFAFAF);

      // repeated START after one byte, then a complete frame
      frame(SADDR, 1'b0, 32'h57000000, 1'b1, 1, 1'b0);
      exp_err++;
      frame(SADDR, 1'b0, 32'h57333573, 1'b1, 4, 1'b1);
      chk("data_rs", data_out, 32'h57333573);

      // reset asserted while the target is driving a data ACK
      start_c;
      wbyte({SADDR, 1'b0}, 1'b1, "ack_addr_r");
      for (int i = 7; i >= 0; i--) wbit(1'(8'hC3 >> i));
      ack_slot = 1'b1;
      sda_m = 1'b1; #Q; scl_m = 1'b1; #Q;
      chk("ack_pre_reset", 32'(sda_oe), 32'd1);
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("midrst");
      reset = 1'b0;
      #Q; scl_m = 1'b0; #Q;
      ack_slot = 1'b0;
      stop_c;
      frame(SADDR, 1'b0, 32'h12345678, 1'b1, 4, 1'b1);
      chk("data_after_reset", data_out, 32'h12345678);

      #(4*Q);
      chk("sb_empty", exp_q.size(), 32'd0);
      chk("stray_oe", stray, 32'd0);
      chk("err_final", err_seen, exp_err);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
